// File: rtl/rram_adc_readout_sequencer.sv
// ---------------------------------------------------------------------------
// rram_adc_readout_sequencer
//
// Reads out a segment of an RRAM array through a bank of shared ADCs. Each
// ADC is multiplexed over MUX_WAYS source lines. For every column of the
// segment the sequencer selects the column, waits for the mux to settle,
// triggers one conversion, captures all ADC results, and streams them out as
// WORDS words over a valid/ready interface tagged with the column index.
//
// Ports
//   CLK, RST       : clock, synchronous active-high reset
//   start_i        : request one segment readout (honoured only in IDLE)
//   seg_width_i    : number of columns to read, 1..MUX_WAYS
//   start_col_i    : first mux column
//   abort_i        : stop at the next safe point
//   busy_o         : high whenever the sequencer is not idle
//   done_o         : one-cycle pulse when a segment completes or is aborted
//   err_o          : one-cycle pulse when a start request is rejected
//   SL_MUX_SEL     : one-hot column select for the SL mux
//   adc_start_o    : one-cycle conversion trigger
//   adc_done_i     : conversion-complete strobe, ADCOUT valid in that cycle
//   ADCOUT         : packed ADC results, ADC[i] at bits [i*ADC_BITS +: ADC_BITS]
//   valid_o/ready_i: output word handshake
//   DATAOUT        : packed ADC results for the current word
//   col_o          : column the current word belongs to
// ---------------------------------------------------------------------------
module rram_adc_readout_sequencer #(
    parameter int NUM_ADC       = 32,
    parameter int ADC_BITS      = 4,
    parameter int MUX_WAYS      = 16,
    parameter int DATAOUT_WIDTH = 64,
    parameter int SETTLE_CYCLES = 2
) (
    input  logic                        CLK,
    input  logic                        RST,
    input  logic                        start_i,
    input  logic [4:0]                  seg_width_i,
    input  logic [3:0]                  start_col_i,
    input  logic                        abort_i,
    output logic                        busy_o,
    output logic                        done_o,
    output logic                        err_o,
    output logic [MUX_WAYS-1:0]         SL_MUX_SEL,
    output logic                        adc_start_o,
    input  logic                        adc_done_i,
    input  logic [NUM_ADC*ADC_BITS-1:0] ADCOUT,
    output logic                        valid_o,
    input  logic                        ready_i,
    output logic [DATAOUT_WIDTH-1:0]    DATAOUT,
    output logic [3:0]                  col_o
);

    localparam int WORDS  = (NUM_ADC * ADC_BITS) / DATAOUT_WIDTH;
    localparam int WIDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;

    typedef enum logic [2:0] {
        IDLE,
        SETTLE,
        CONV,
        WAIT_ADC,
        OUT,
        DONE
    } state_t;

    state_t                                 state;
    state_t                                 state_nxt;
    logic [3:0]                             settle_cnt;
    logic [3:0]                             col;
    logic [4:0]                             seg_width;
    logic [4:0]                             col_cnt;
    logic [WIDX_W-1:0]                      word_idx;
    logic                                   abort_pend;
    logic                                   err_q;
    // Word w of the capture is ADCOUT[w*DATAOUT_WIDTH +: DATAOUT_WIDTH], so
    // word 0 carries the lowest-numbered ADCs with ADC[0] in its LSBs.
    logic [WORDS-1:0][DATAOUT_WIDTH-1:0]    adc_words;

    logic start_ok;
    logic settle_last;
    logic last_word;
    logic last_col;
    logic sel_active;

    assign start_ok    = start_i && (seg_width_i != 5'd0) && (seg_width_i <= 5'(MUX_WAYS));
    assign settle_last = (settle_cnt == 4'(SETTLE_CYCLES - 1));
    assign last_word   = (word_idx == WIDX_W'(WORDS - 1));
    assign last_col    = ((col_cnt + 5'd1) == seg_width);

    always_comb begin
        // NOTE: next state gets a default before the case so every path
        // assigns it and no latch is inferred.
        state_nxt = state;
        case (state)
            IDLE:     if (start_ok) state_nxt = SETTLE;
            SETTLE: begin
                if (abort_i)          state_nxt = DONE;
                else if (settle_last) state_nxt = CONV;
            end
            CONV:     state_nxt = abort_i ? DONE : WAIT_ADC;
            WAIT_ADC: if (adc_done_i) state_nxt = OUT;
            OUT: begin
                // An abort seen during WAIT_ADC/OUT only takes effect once the
                // captured column has been fully delivered.
                if (ready_i && last_word)
                    state_nxt = (abort_pend || abort_i || last_col) ? DONE : SETTLE;
            end
            DONE:     state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        // NOTE: all state here uses non-blocking assignment so every register
        // samples pre-edge values regardless of statement order.
        if (RST) begin
            state      <= IDLE;
            settle_cnt <= '0;
            col        <= '0;
            seg_width  <= '0;
            col_cnt    <= '0;
            word_idx   <= '0;
            abort_pend <= 1'b0;
            err_q      <= 1'b0;
            // NOTE: the capture register is cleared too, so nothing from an
            // interrupted readout can leak into a later one.
            adc_words  <= '0;
        end else begin
            state <= state_nxt;
            err_q <= (state == IDLE) && start_i && !start_ok;

            if ((state == IDLE) && start_ok) begin
                col        <= start_col_i;
                seg_width  <= seg_width_i;
                col_cnt    <= '0;
                abort_pend <= 1'b0;
            end

            settle_cnt <= (state == SETTLE) ? settle_cnt + 4'd1 : 4'd0;

            if (((state == WAIT_ADC) || (state == OUT)) && abort_i)
                abort_pend <= 1'b1;

            if ((state == WAIT_ADC) && adc_done_i) begin
                adc_words <= ADCOUT;
                word_idx  <= '0;
            end

            if ((state == OUT) && ready_i) begin
                if (last_word) begin
                    word_idx <= '0;
                    col_cnt  <= col_cnt + 5'd1;
                    col      <= (col == 4'(MUX_WAYS - 1)) ? 4'd0 : col + 4'd1;
                end else begin
                    word_idx <= word_idx + WIDX_W'(1);
                end
            end
        end
    end

    assign sel_active  = (state == SETTLE) || (state == CONV) ||
                         (state == WAIT_ADC) || (state == OUT);
    assign SL_MUX_SEL  = sel_active ? (MUX_WAYS'(1) << col) : '0;
    assign busy_o      = (state != IDLE);
    assign done_o      = (state == DONE);
    assign err_o       = err_q;
    assign adc_start_o = (state == CONV);
    assign valid_o     = (state == OUT);
    assign DATAOUT     = valid_o ? adc_words[word_idx] : '0;
    assign col_o       = valid_o ? col : 4'd0;

endmodule

// File: tb/tb_rram_adc_readout_sequencer.sv
// ---------------------------------------------------------------------------
// Testbench for rram_adc_readout_sequencer.
// An ADC model answers each conversion with random (or patterned) results
// and pushes the words the reference expects; a monitor pops and compares
// them as the DUT presents output words. Stimulus tasks drive segments,
// aborts, rejected starts, stalls and a mid-readout reset.
// ---------------------------------------------------------------------------
module tb_rram_adc_readout_sequencer;

    localparam int NUM_ADC       = 32;
    localparam int ADC_BITS      = 4;
    localparam int MUX_WAYS      = 16;
    localparam int DW            = 64;
    localparam int SETTLE        = 2;
    localparam int WORDS         = NUM_ADC * ADC_BITS / DW;
    localparam int ADCS_PER_WORD = DW / ADC_BITS;

    logic                        CLK = 1'b0;
    logic                        RST;
    logic                        start_i;
    logic [4:0]                  seg_width_i;
    logic [3:0]                  start_col_i;
    logic                        abort_i;
    logic                        busy_o;
    logic                        done_o;
    logic                        err_o;
    logic [MUX_WAYS-1:0]         SL_MUX_SEL;
    logic                        adc_start_o;
    logic                        adc_done_i;
    logic [NUM_ADC*ADC_BITS-1:0] ADCOUT;
    logic                        valid_o;
    logic                        ready_i;
    logic [DW-1:0]               DATAOUT;
    logic [3:0]                  col_o;

    typedef struct {
        logic [DW-1:0] data;
        logic [3:0]    col;
    } exp_t;

    exp_t exp_q[$];

    int n_tests = 0;
    int n_fail  = 0;

    // Counters owned by the ADC model / monitor; stimulus reads them only.
    int conv_cnt = 0;
    int xfer_cnt = 0;
    int done_cnt = 0;
    int err_cnt  = 0;

    // Context owned by the stimulus process.
    int conv_base     = 0;
    int cur_start_col = 0;
    int adc_lat_fixed = 0;
    bit adc_pattern   = 1'b0;
    bit spur_req      = 1'b0;

    always #5 CLK = ~CLK;

    rram_adc_readout_sequencer #(
        .NUM_ADC       (NUM_ADC),
        .ADC_BITS      (ADC_BITS),
        .MUX_WAYS      (MUX_WAYS),
        .DATAOUT_WIDTH (DW),
        .SETTLE_CYCLES (SETTLE)
    ) dut (
        .CLK         (CLK),
        .RST         (RST),
        .start_i     (start_i),
        .seg_width_i (seg_width_i),
        .start_col_i (start_col_i),
        .abort_i     (abort_i),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .err_o       (err_o),
        .SL_MUX_SEL  (SL_MUX_SEL),
        .adc_start_o (adc_start_o),
        .adc_done_i  (adc_done_i),
        .ADCOUT      (ADCOUT),
        .valid_o     (valid_o),
        .ready_i     (ready_i),
        .DATAOUT     (DATAOUT),
        .col_o       (col_o)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        n_tests++;
        n_fail++;
        $display("FAIL %s: bound expired (t=%0t)", name, $time);
    endtask

    // ADC behavioural model and expectation producer.
    initial begin : adc_model
        int   lat;
        int   col;
        int   vals[NUM_ADC];
        logic [DW-1:0] word;
        adc_done_i = 1'b0;
        ADCOUT     = '0;
        forever begin
            @(negedge CLK);
            if (adc_start_o) begin
                conv_cnt++;
                col = (cur_start_col + (conv_cnt - conv_base - 1)) % MUX_WAYS;
                check("mux_sel_at_conv", 64'(SL_MUX_SEL), 64'(1) << col);
                lat = (adc_lat_fixed > 0) ? adc_lat_fixed : int'($urandom_range(1, 5));
                for (int i = 0; i < NUM_ADC; i++)
                    vals[i] = adc_pattern ? (i % 16) : int'($urandom_range(0, 15));
                repeat (lat) @(posedge CLK);
                #2;
                adc_done_i = 1'b1;
                for (int i = 0; i < NUM_ADC; i++)
                    ADCOUT[i*ADC_BITS +: ADC_BITS] = ADC_BITS'(vals[i]);
                for (int w = 0; w < WORDS; w++) begin
                    word = '0;
                    for (int j = 0; j < ADCS_PER_WORD; j++)
                        word = word + (64'(vals[w*ADCS_PER_WORD + j]) << (ADC_BITS * j));
                    exp_q.push_back('{data: word, col: 4'(col)});
                end
                @(negedge CLK);
                check("valid_low_in_done_cycle", 64'(valid_o), 64'd0);
                check("adc_start_single_cycle", 64'(adc_start_o), 64'd0);
                @(posedge CLK);
                #2;
                adc_done_i = 1'b0;
                ADCOUT     = {$urandom, $urandom, $urandom, $urandom};
                @(negedge CLK);
                check("valid_one_cycle_after_done", 64'(valid_o), 64'd1);
            end else if (spur_req) begin
                @(posedge CLK);
                #2;
                adc_done_i = 1'b1;
                ADCOUT     = {$urandom, $urandom, $urandom, $urandom};
                @(posedge CLK);
                #2;
                adc_done_i = 1'b0;
            end
        end
    end

    // Output monitor: compares every presented word against the queue head.
    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge CLK);
            if (done_o) begin
                done_cnt++;
                check("mux_sel_zero_in_done", 64'(SL_MUX_SEL), 64'd0);
            end
            if (err_o) err_cnt++;
            if (!busy_o) check("mux_sel_zero_in_idle", 64'(SL_MUX_SEL), 64'd0);
            if (valid_o) begin
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_word: got 0x%0h col %0d, expected no word (t=%0t)",
                             DATAOUT, col_o, $time);
                end else begin
                    e = exp_q[0];
                    check("dataout", DATAOUT, e.data);
                    check("col_o", 64'(col_o), 64'(e.col));
                    check("mux_sel_in_out", 64'(SL_MUX_SEL), 64'(1) << e.col);
                    if (ready_i) begin
                        void'(exp_q.pop_front());
                        xfer_cnt++;
                    end
                end
            end
        end
    end

    // abort_mode: 0 none, 1 abort in WAIT_ADC of column 0, 2 abort in SETTLE.
    // rmode: 0 ready always, 1 random ready, 2 stall 5 cycles on word 0.
    task automatic run_txn(input int width, input int scol, input int abort_mode,
                           input int rmode, input bit poke);
        int exp_cols;
        int d0;
        int e0;
        int x0;
        int stall;
        bit seen_conv;
        bit abort_next;
        bit finished;
        exp_cols      = (abort_mode == 2) ? 0 : (abort_mode == 1) ? 1 : width;
        d0            = done_cnt;
        e0            = err_cnt;
        x0            = xfer_cnt;
        conv_base     = conv_cnt;
        cur_start_col = scol;
        stall         = 5;
        seen_conv     = 1'b0;
        abort_next    = 1'b0;
        finished      = 1'b0;
        @(posedge CLK);
        #2;
        start_i     = 1'b1;
        seg_width_i = 5'(width);
        start_col_i = 4'(scol);
        for (int cyc = 1; cyc <= 3000 && !finished; cyc++) begin
            @(posedge CLK);
            #2;
            start_i = 1'b0;
            abort_i = 1'b0;
            if (poke && cyc == 4) begin
                start_i     = 1'b1;
                seg_width_i = 5'd0;
            end
            if (abort_mode == 2 && cyc == 1) abort_i = 1'b1;
            if (abort_next) begin
                abort_i    = 1'b1;
                abort_next = 1'b0;
            end
            case (rmode)
                0: ready_i = 1'b1;
                1: ready_i = 1'($urandom_range(0, 1));
                default: begin
                    if (valid_o && stall > 0) begin
                        ready_i = 1'b0;
                        stall--;
                    end else begin
                        ready_i = 1'b1;
                        if (!valid_o) stall = 5;
                    end
                end
            endcase
            @(negedge CLK);
            if (cyc == 1) begin
                check("busy_after_start", 64'(busy_o), 64'd1);
                check("mux_sel_in_settle", 64'(SL_MUX_SEL), 64'(1) << scol);
            end
            if (adc_start_o && !seen_conv) begin
                seen_conv = 1'b1;
                check("adc_start_latency", 64'(cyc), 64'(SETTLE + 1));
                if (abort_mode == 1) abort_next = 1'b1;
            end
            if (done_o) finished = 1'b1;
        end
        if (!finished) fail_now("txn_done_timeout");
        @(posedge CLK);
        #2;
        start_i = 1'b0;
        abort_i = 1'b0;
        ready_i = 1'b0;
        @(negedge CLK);
        check("done_single_pulse", 64'(done_o), 64'd0);
        check("idle_after_done", 64'(busy_o), 64'd0);
        check("done_count", 64'(done_cnt - d0), 64'd1);
        check("no_err_in_txn", 64'(err_cnt - e0), 64'd0);
        check("conversions", 64'(conv_cnt - conv_base), 64'(exp_cols));
        check("transfers", 64'(xfer_cnt - x0), 64'(exp_cols * WORDS));
        check("queue_drained", 64'(exp_q.size()), 64'd0);
    endtask

    task automatic run_bad(input int width);
        @(posedge CLK);
        #2;
        start_i     = 1'b1;
        seg_width_i = 5'(width);
        start_col_i = 4'($urandom_range(0, 15));
        @(posedge CLK);
        #2;
        start_i = 1'b0;
        @(negedge CLK);
        check("err_pulse", 64'(err_o), 64'd1);
        check("busy_on_reject", 64'(busy_o), 64'd0);
        @(negedge CLK);
        check("err_single_pulse", 64'(err_o), 64'd0);
        check("busy_after_reject", 64'(busy_o), 64'd0);
    endtask

    task automatic run_reset_mid_out();
        int d0;
        bit seen;
        d0            = done_cnt;
        conv_base     = conv_cnt;
        cur_start_col = 7;
        seen          = 1'b0;
        @(posedge CLK);
        #2;
        start_i     = 1'b1;
        seg_width_i = 5'd2;
        start_col_i = 4'd7;
        @(posedge CLK);
        #2;
        start_i = 1'b0;
        ready_i = 1'b0;
        for (int cyc = 0; cyc < 200 && !seen; cyc++) begin
            @(negedge CLK);
            if (valid_o) seen = 1'b1;
        end
        if (!seen) fail_now("reset_wait_valid");
        @(posedge CLK);
        #2;
        RST = 1'b1;
        @(posedge CLK);
        #1;
        exp_q.delete();
        RST = 1'b0;
        @(negedge CLK);
        check("rst_valid", 64'(valid_o), 64'd0);
        check("rst_mux_sel", 64'(SL_MUX_SEL), 64'd0);
        check("rst_busy", 64'(busy_o), 64'd0);
        check("rst_dataout", DATAOUT, 64'd0);
        check("rst_col", 64'(col_o), 64'd0);
        repeat (4) @(negedge CLK);
        check("rst_no_done", 64'(done_cnt - d0), 64'd0);
    endtask

    initial begin : watchdog
        #900000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin : main
        RST         = 1'b1;
        start_i     = 1'b0;
        seg_width_i = 5'd0;
        start_col_i = 4'd0;
        abort_i     = 1'b0;
        ready_i     = 1'b0;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        check("reset_busy", 64'(busy_o), 64'd0);
        check("reset_done", 64'(done_o), 64'd0);
        check("reset_err", 64'(err_o), 64'd0);
        check("reset_mux_sel", 64'(SL_MUX_SEL), 64'd0);
        check("reset_adc_start", 64'(adc_start_o), 64'd0);
        check("reset_valid", 64'(valid_o), 64'd0);
        check("reset_dataout", DATAOUT, 64'd0);
        check("reset_col", 64'(col_o), 64'd0);
        @(posedge CLK);
        #2;
        RST = 1'b0;

        // Patterned ADC results, fixed 3-cycle conversion, always ready.
        adc_pattern   = 1'b1;
        adc_lat_fixed = 3;
        run_txn(2, 0, 0, 0, 1'b0);
        adc_pattern   = 1'b0;
        adc_lat_fixed = 0;

        // Column wrap 15 -> 0, with a start poked mid-run that must be ignored.
        run_txn(3, 15, 0, 0, 1'b1);

        // Consumer stalls on word 0 of every column.
        run_txn(2, 4, 0, 2, 1'b0);

        // Rejected starts.
        run_bad(0);
        run_bad(17);
        run_bad(31);

        // Aborts.
        run_txn(4, 0, 1, 0, 1'b0);
        run_txn(5, 9, 2, 0, 1'b0);

        // Stray conversion strobes while idle must not produce output.
        spur_req = 1'b1;
        repeat (8) begin
            @(negedge CLK);
            check("spurious_valid", 64'(valid_o), 64'd0);
            check("spurious_busy", 64'(busy_o), 64'd0);
        end
        spur_req = 1'b0;
        repeat (3) @(negedge CLK);

        // Reset in the middle of an output handshake, then a normal run.
        run_reset_mid_out();
        run_txn(2, 3, 0, 1, 1'b0);

        // Randomized segments.
        repeat (20) begin
            run_txn(int'($urandom_range(1, 16)), int'($urandom_range(0, 15)),
                    ($urandom_range(0, 5) == 0) ? 1 : 0,
                    int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)));
        end

        repeat (3) @(posedge CLK);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
